// File: rtl/stream_mux_if.sv
// stream_mux_if -- bundles the stream mux channel, output and selector signals.
//   master : upstream/downstream side. It drives the channel data and valid bits,
//            the selector controls and out_ready.
//   slave  : the mux itself. It drives in_ready, out_data, out_valid and cur_sel.
// WIDTH and CHANNELS must match the parameters of the attached stream_mux.
interface stream_mux_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      sel_load;
  logic                      rr_mode;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SEL_W-1:0]          cur_sel;

  modport master (
    output in_data, in_valid, sel, sel_load, rr_mode, out_ready,
    input  in_ready, out_data, out_valid, cur_sel
  );

  modport slave (
    input  in_data, in_valid, sel, sel_load, rr_mode, out_ready,
    output in_ready, out_data, out_valid, cur_sel
  );
endinterface

// File: rtl/stream_mux.sv
// stream_mux -- N-to-1 valid/ready stream multiplexer with a single registered
// output stage.
//   clk   : the only clock. All state updates on its rising edge.
//   rst_n : asynchronous, active-low reset. While it is low, all in_ready bits
//           are 0, out_valid is 0, out_data is 0 and cur_sel is 0.
//   bus   : stream_mux_if.slave. It carries the per-channel data, valid and
//           ready, the sel/sel_load/rr_mode controls, out_data/out_valid/
//           out_ready and cur_sel.
// Only the granted channel (cur_sel) sees ready. That channel is ready whenever
// the output register is empty or is draining in the same cycle, which gives
// full throughput with no bubble.
// Optional round-robin arbitration is built only when STREAM_MUX_RR_EN is
// defined. In that case rr_mode=1 lets the arbiter move cur_sel, and sel_load
// is ignored. Without the macro, rr_mode is unused and no arbiter exists.

// Per-channel lane: grant decode, ready gating and data masking feeding the
// AND-OR output mux.
module stream_mux_lane #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] cur_sel,
  input  logic             can_acc,
  input  logic [WIDTH-1:0] data,
  output logic             rdy,
  output logic [WIDTH-1:0] gdata
);
  logic gnt;

  assign gnt   = (cur_sel == SEL_W'(IDX));
  assign rdy   = gnt & can_acc;
  assign gdata = gnt ? data : '0;
endmodule

module stream_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  stream_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0]                 out_data_q;
  logic                             out_valid_q;
  logic [SEL_W-1:0]                 cur_sel_q;
  logic [SEL_W-1:0]                 sel_nxt;
  logic [SEL_W-1:0]                 ld_sel;
  logic                             sel_ok;
  logic                             can_acc;
  logic                             in_fire;
  logic [CHANNELS-1:0]              rdy;
  logic [CHANNELS-1:0][WIDTH-1:0]   gdata;
  logic [WIDTH-1:0]                 mux_data;

  // Gating with rst_n keeps every ready low while reset is asserted, even
  // though the registered state already reads "empty, channel 0".
  assign can_acc = rst_n & (~out_valid_q | bus.out_ready);

  for (genvar lane = 0; lane < CHANNELS; lane++) begin : g_lane
    stream_mux_lane #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W),
      .IDX   (lane)
    ) u_lane (
      .cur_sel (cur_sel_q),
      .can_acc (can_acc),
      .data    (bus.in_data[lane*WIDTH +: WIDTH]),
      .rdy     (rdy[lane]),
      .gdata   (gdata[lane])
    );
  end

  // At most one lane is granted, so OR-ing the masked lanes forms the mux.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < CHANNELS; i++) mux_data = mux_data | gdata[i];
  end

  assign in_fire = |(rdy & bus.in_valid);

  // An out-of-range selector value is dropped and the old grant is kept. The
  // extra top bit keeps the compare meaningful when CHANNELS is a power of 2.
  assign sel_ok = ({1'b0, bus.sel} < (SEL_W+1)'(CHANNELS));
  assign ld_sel = (bus.sel_load && sel_ok) ? bus.sel : cur_sel_q;

`ifdef STREAM_MUX_RR_EN
  // Rotate the valid vector so that rot[j] is channel (cur_sel + j) mod N.
  // The first set bit at j >= 1 is then the next requester in wrap order.
  // Index j == N (rot[0]) is the current channel itself, which is the last
  // candidate. cur_sel doubles as the round-robin pointer.
  logic [2*CHANNELS-1:0] vv;
  logic [CHANNELS-1:0]   rot;
  logic [SEL_W-1:0]      rr_next;
  logic                  rr_found;
  logic                  cur_vld;

  always_comb begin
    vv       = {bus.in_valid, bus.in_valid} >> cur_sel_q;
    rot      = vv[CHANNELS-1:0];
    rr_found = 1'b0;
    rr_next  = cur_sel_q;
    for (int j = 1; j <= CHANNELS; j++) begin
      if (!rr_found && rot[j % CHANNELS]) begin
        rr_found = 1'b1;
        rr_next  = SEL_W'((int'(cur_sel_q) + j) % CHANNELS);
      end
    end
  end

  assign cur_vld = rot[0];

  // A grant that is holding a stalled word stays put. Otherwise the arbiter
  // moves on after a transfer, or away from an idle channel. If nobody
  // requests, the grant holds.
  always_comb begin
    sel_nxt = ld_sel;
    if (bus.rr_mode) begin
      sel_nxt = cur_sel_q;
      if ((in_fire || !cur_vld) && rr_found) sel_nxt = rr_next;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = bus.rr_mode;
  assign sel_nxt   = ld_sel;
`endif

  // Output register. A load takes priority over a drain, so a same-cycle
  // drain plus accept keeps out_valid high with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cur_sel_q   <= '0;
    end else begin
      if (in_fire) begin
        out_data_q  <= mux_data;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      cur_sel_q <= sel_nxt;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cur_sel   = cur_sel_q;
endmodule

// File: tb/tb_stream_mux.sv
// Randomized scoreboard bench for stream_mux. The stimulus process drives the
// inputs at each negedge. At negedge+3 it applies the stream rules to a
// queue-based model, pushes every word it expects the DUT to accept, and checks
// ready, grant and valid. A separate monitor at negedge+2 compares out_data
// against the head of the queue while out_valid is high, and pops on out_ready.
// A second 5-channel instance exercises out-of-range selector values.
module tb_stream_mux;
  localparam int W  = 32;
  localparam int CH = 4;
  localparam int SW = 2;
`ifdef STREAM_MUX_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
  stream_mux_if #(.WIDTH(8), .CHANNELS(5))  bus5 ();

  stream_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  stream_mux #(.WIDTH(8), .CHANNELS(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [W-1:0]  sb[$];
  logic [SW-1:0] m_sel;
  bit            m_held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of the stream rules for one cycle, evaluated with this cycle's inputs.
  task automatic model_eval();
    bit           can, fire, found;
    logic [CH-1:0] exp_rdy;
    int           idx;
    logic [SW-1:0] nsel;
    can     = !m_held || bus.out_ready;
    exp_rdy = can ? (4'b0001 << m_sel) : 4'b0000;
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("cur_sel", 64'(bus.cur_sel), 64'(m_sel));
    check("out_valid", 64'(bus.out_valid), 64'(m_held));
    fire = can && bus.in_valid[m_sel];
    if (fire) sb.push_back(bus.in_data[int'(m_sel)*W +: W]);
    if (fire) m_held = 1'b1;
    else if (bus.out_ready) m_held = 1'b0;
    nsel = m_sel;
    if (RR_EN && bus.rr_mode) begin
      if (fire || !bus.in_valid[m_sel]) begin
        found = 1'b0;
        for (int k = 1; k <= CH; k++) begin
          idx = (int'(m_sel) + k) % CH;
          if (!found && bus.in_valid[idx[SW-1:0]]) begin
            found = 1'b1;
            nsel  = idx[SW-1:0];
          end
        end
      end
    end else if (bus.sel_load && int'(bus.sel) < CH) begin
      nsel = bus.sel;
    end
    m_sel = nsel;
  endtask

  task automatic step();
    #3;
    model_eval();
    @(negedge clk);
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] d);
    bus.in_data[c*W +: W] = d;
  endtask

  // Monitor: compare the presented word against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL out_extra: got word %0h expected no output", bus.out_data);
        end else begin
          check("out_data", 64'(bus.out_data), 64'(sb[0]));
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rr_seq[5];
    rr_seq = '{0, 1, 2, 3, 0};
    m_sel  = '0;
    m_held = 1'b0;
    rst_n  = 1'b0;
    bus.in_data = '0; bus.in_valid = '0; bus.sel = '0; bus.sel_load = 1'b0;
    bus.rr_mode = 1'b0; bus.out_ready = 1'b1;
    bus5.in_data = '0; bus5.in_valid = '0; bus5.sel = '0; bus5.sel_load = 1'b0;
    bus5.rr_mode = 1'b0; bus5.out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_data", 64'(bus.out_data), 64'h0);
    check("rst_cur_sel", 64'(bus.cur_sel), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset accepts channel 0
    bus.in_valid = 4'b0001; set_ch(0, 32'h1234_5678);
    step();
    bus.in_valid = '0;
    check("first_out_data", 64'(bus.out_data), 64'h1234_5678);
    check("first_out_valid", 64'(bus.out_valid), 64'h1);
    step();

    // Selector range on a 5-channel instance
    bus5.sel = 3'd3; bus5.sel_load = 1'b1; step();
    check("c5_sel3", 64'(bus5.cur_sel), 64'd3);
    bus5.sel = 3'd7; step();
    check("c5_sel7_ignored", 64'(bus5.cur_sel), 64'd3);
    bus5.sel = 3'd5; step();
    check("c5_sel5_ignored", 64'(bus5.cur_sel), 64'd3);
    bus5.sel = 3'd4; step();
    check("c5_sel4", 64'(bus5.cur_sel), 64'd4);
    bus5.sel_load = 1'b0; bus5.sel = 3'd0; step();
    check("c5_hold", 64'(bus5.cur_sel), 64'd4);

    // Load selector 2 and pass a word from channel 2
    bus.sel = 2'd2; bus.sel_load = 1'b1; step();
    bus.sel_load = 1'b0;
    check("sel2_cur_sel", 64'(bus.cur_sel), 64'd2);
    check("sel2_in_ready", 64'(bus.in_ready), 64'b0100);
    bus.in_valid = 4'b0100; set_ch(2, 32'h1111_2222); step();
    bus.in_valid = '0;
    check("sel2_out_data", 64'(bus.out_data), 64'h1111_2222);

    // Five-cycle stall with channel 0 still offering a word
    bus.sel = 2'd0; bus.sel_load = 1'b1; step();
    bus.sel_load = 1'b0;
    bus.in_valid = 4'b0001; set_ch(0, 32'hAAAA_0001); step();
    bus.out_ready = 1'b0; set_ch(0, 32'hBBBB_0002);
    for (int s = 0; s < 5; s++) begin
      step();
      check("stall_out_data", 64'(bus.out_data), 64'hAAAA_0001);
      check("stall_in_ready", 64'(bus.in_ready), 64'h0);
    end
    bus.out_ready = 1'b1; step();
    bus.in_valid = '0;
    check("nobubble_data", 64'(bus.out_data), 64'hBBBB_0002);
    check("nobubble_valid", 64'(bus.out_valid), 64'h1);
    step();

    // Asynchronous reset while a word is stalled on channel 3
    bus.sel = 2'd3; bus.sel_load = 1'b1; step();
    bus.sel_load = 1'b0;
    bus.in_valid = 4'b1000; set_ch(3, 32'hCCCC_0003); step();
    bus.in_valid = '0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'h0);
    check("arst_cur_sel", 64'(bus.cur_sel), 64'h0);
    check("arst_out_data", 64'(bus.out_data), 64'h0);
    check("arst_in_ready", 64'(bus.in_ready), 64'h0);
    sb.delete();
    m_held = 1'b0;
    m_sel  = '0;
    @(negedge clk);
    rst_n = 1'b1; bus.out_ready = 1'b1;

    // Randomized traffic with alternating rr_mode phases
    for (int i = 0; i < 800; i++) begin
      bus.in_valid  = CH'($urandom);
      for (int c = 0; c < CH; c++) set_ch(c, $urandom);
      bus.out_ready = ($urandom % 10) < 7;
      bus.sel_load  = ($urandom % 5) == 0;
      bus.sel       = SW'($urandom);
      bus.rr_mode   = ((i / 100) % 2) == 1;
      step();
    end

    // Round-robin sweep over four requesting channels
    if (RR_EN) begin
      bus.rr_mode = 1'b0; bus.in_valid = '0; bus.out_ready = 1'b1;
      bus.sel = 2'd0; bus.sel_load = 1'b1; step();
      bus.sel_load = 1'b0; bus.rr_mode = 1'b1; bus.in_valid = 4'b1111;
      for (int c = 0; c < CH; c++) set_ch(c, 32'hC0DE_0000 + c);
      for (int s = 0; s < 5; s++) begin
        step();
        check("rr_seq", 64'(bus.out_data), 64'(32'hC0DE_0000 + rr_seq[s]));
      end
    end

    // Drain and confirm nothing was dropped
    bus.in_valid = '0; bus.out_ready = 1'b1; bus.sel_load = 1'b0; bus.rr_mode = 1'b0;
    step(); step(); step();
    check("sb_empty", 64'(sb.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of every channel.
REQ-002 SHALL have parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-003 SHALL derive local SEL_W = $clog2(CHANNELS); it is not overridable.
REQ-004 clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel valid.
REQ-008 in_ready  output  CHANNELS  per-channel ready.
REQ-009 sel  input  SEL_W  requested channel index.
REQ-010 sel_load  input  1  one-cycle strobe; loads sel into the selector register.
REQ-011 rr_mode  input  1  1 = round-robin arbitration; 0 = selector-driven.
REQ-012 out_data  output  WIDTH  registered output data.
REQ-013 out_valid  output  1  output valid.
REQ-014 out_ready  input  1  downstream ready.
REQ-015 cur_sel  output  SEL_W  channel currently granted.

Function
REQ-016 SHALL transfer on an input when in_valid[i] && in_ready[i], and on the output when out_valid && out_ready.
REQ-017 SHALL drive in_ready[i] = (i == cur_sel) && (!out_valid || out_ready); every other in_ready bit is 0.
REQ-018 SHALL register accepted data into out_data and set out_valid on the next edge: latency 1 cycle, throughput 1 word/cycle with out_ready held high.
REQ-019 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid after an output transfer with no simultaneous input transfer.
REQ-021 SHALL on a same-cycle output transfer and input transfer load the new word with out_valid staying 1, with no bubble.
REQ-022 In selector mode (rr_mode=0), sel_load with sel < CHANNELS SHALL update cur_sel on the next edge; sel >= CHANNELS SHALL be ignored and cur_sel kept.
REQ-023 A sel_load in the same cycle as an input transfer SHALL complete that transfer on the old cur_sel; the new channel applies from the next cycle.
REQ-024 SHALL never drop or duplicate a word: each accepted word appears exactly once on the output.

Reset
REQ-025 On rst_n low, SHALL immediately force out_valid=0, out_data=0, cur_sel=0, all in_ready=0, and the round-robin pointer=0, independent of clk.
REQ-026 A reset during an output stall SHALL discard the held word.
REQ-027 After rst_n deasserts, SHALL accept input on the first rising edge.

Configuration
REQ-028 With macro STREAM_MUX_RR_EN defined, rr_mode=1 SHALL make cur_sel advance, after each input transfer, to the next channel above the last granted one (wrapping CHANNELS-1 -> 0) that has in_valid high; sel_load is ignored.
REQ-029 In round-robin mode, when the granted channel has in_valid low, SHALL move cur_sel to the next requesting channel in wrap order on the next edge. If no channel requests, cur_sel SHALL hold.
REQ-030 Without STREAM_MUX_RR_EN, rr_mode SHALL be ignored (treated as 0) and no arbitration logic SHALL be synthesised.

Verification
REQ-031 Defaults; ch0=32'h1234_5678 valid, out_ready=1 -> out_data=32'h1234_5678, out_valid=1 one cycle after the transfer.
REQ-032 sel=2'b10 with sel_load, ch2=32'h1111_2222 -> cur_sel=2 next cycle; output is 32'h1111_2222; in_ready=4'b0100.
REQ-033 out_ready=0 for 5 cycles with ch0 valid -> out_data held and in_ready[0]=0 for those 5 cycles; the word drains once out_ready=1, with no loss.
REQ-034 sel=3'd5 with CHANNELS=4 (SEL_W=2 cannot encode it; use CHANNELS=5, sel=3'd7) -> cur_sel is unchanged.
REQ-035 STREAM_MUX_RR_EN defined, rr_mode=1, all four channels valid, out_ready=1 -> output sequence comes from channels 0,1,2,3,0 on consecutive cycles.
REQ-036 rst_n pulled low while out_valid=1 is stalled -> out_valid=0 and cur_sel=0 before the next clk edge.
